// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_e : FSM state encoding (idle / run / done)
//   clog2   : bit counter width for a given operand width, minimum 1
package serial_add_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Smallest r with 2**r >= value, never less than 1 so the counter always has a bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        r = i + 1;
      end
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fa_decoder3x8.sv
// Combinational full adder built from a 3-to-8 one-hot decoder.
// Ports:
//   a_i, b_i, c_i : addend bits and carry in
//   sum_o         : OR of minterms 1, 2, 4, 7
//   carry_o       : OR of minterms 3, 5, 6, 7
module fa_decoder3x8 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);

  logic [7:0] minterm;

  always_comb begin
    minterm = 8'b0000_0001 << {a_i, b_i, c_i};
    sum_o   = minterm[1] | minterm[2] | minterm[4] | minterm[7];
    carry_o = minterm[3] | minterm[5] | minterm[6] | minterm[7];
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands one bit per clock, LSB first.
// Optional feature: define SERIAL_ADD_OVF_EN to build the signed-overflow flag; otherwise
// ovf is tied to 0.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start, a, b   : request and operands, accepted only in idle
//   busy          : high while bit steps are in progress
//   done          : one-cycle pulse when sum/cout/ovf are valid
//   sum, cout     : result and carry out, held until the next accepted start
//   ovf           : signed overflow of the last addition
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned     CntW    = clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;

  logic             load;
  logic             step;
  logic             last_step;
  logic             bit_sum;
  logic             bit_carry;

  fa_decoder3x8 u_fa (
    .a_i     (a_q[0]),
    .b_i     (b_q[0]),
    .c_i     (carry_q),
    .sum_o   (bit_sum),
    .carry_o (bit_carry)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun:  if (cnt_q == LastCnt) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  // Datapath
  always_comb begin
    load      = (state_q == StIdle) && start;
    step      = (state_q == StRun);
    last_step = step && (cnt_q == LastCnt);

    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;

    if (load) begin
      a_d     = a;
      b_d     = b;
      sum_d   = '0;
      cnt_d   = '0;
      carry_d = 1'b0;
    end else if (step) begin
      // After WIDTH shifts the first sum bit has walked down to bit 0.
      sum_d   = {bit_sum, sum_q[WIDTH-1:1]};
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      cnt_d   = cnt_q + CntW'(1);
      carry_d = bit_carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  assign sum  = sum_q;
  // The carry flop holds the MSB carry out once the last step has run.
  assign cout = carry_q;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q, ovf_d;

  // carry_q is the carry into the MSB during the final step.
  always_comb begin
    ovf_d = ovf_q;
    if (load) begin
      ovf_d = 1'b0;
    end else if (last_step) begin
      ovf_d = carry_q ^ bit_carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_last_step;
  assign unused_last_step = last_step;
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8),
    .ovf   (ovf8)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4),
    .ovf   (ovf4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] q8[$];
  logic [5:0] q4[$];
  logic [9:0] e8;
  logic [5:0] e4;
  int         last_done4 = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Reference: plain integer arithmetic, returns {ovf, cout, sum}.
  function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y);
    int unsigned u;
    int          s;
    logic        o;
    u = 32'(x) + 32'(y);
    s = int'($signed(x)) + int'($signed(y));
`ifdef SERIAL_ADD_OVF_EN
    o = (s > 127) || (s < -128);
`else
    o = 1'b0;
`endif
    return {o, u[8:0]};
  endfunction

  function automatic logic [5:0] model4(input logic [3:0] x, input logic [3:0] y);
    int unsigned u;
    int          s;
    logic        o;
    u = 32'(x) + 32'(y);
    s = int'($signed(x)) + int'($signed(y));
`ifdef SERIAL_ADD_OVF_EN
    o = (s > 7) || (s < -8);
`else
    o = 1'b0;
`endif
    return {o, u[4:0]};
  endfunction

  // Monitors: pop the expected result whenever a done pulse appears.
  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done8: got done with sum %0h, required no done", sum8);
      end else begin
        e8 = q8.pop_front();
        chk("result8", {22'd0, ovf8, cout8, sum8}, {22'd0, e8});
        chk("busy_at_done8", {31'd0, busy8}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done4) begin
      if (q4.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done4: got done with sum %0h, required no done", sum4);
      end else begin
        e4 = q4.pop_front();
        chk("result4", {26'd0, ovf4, cout4, sum4}, {26'd0, e4});
      end
      if (last_done4 >= 0) chk("period4", cyc - last_done4, 32'd6);
      last_done4 = cyc;
    end
  end

  // One WIDTH=8 operation: checks latency, busy length and result hold.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib);
    int   n, nb;
    logic seen;
    logic [9:0] exp;
    exp = model8(ia, ib);
    @(negedge clk);
    a8 = ia; b8 = ib; start8 = 1'b1;
    q8.push_back(exp);
    @(posedge clk);
    #1 start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    n = 0; nb = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (busy8) nb++;
      if (done8) seen = 1'b1;
    end
    if (!seen) timeout("done8_wait");
    chk("latency8", n, 32'd9);
    chk("busy_cycles8", nb, 32'd8);
    repeat (3) @(negedge clk);
    chk("hold8", {22'd0, ovf8, cout8, sum8}, {22'd0, exp});
  endtask

  int n;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_sum", {24'd0, sum8}, 32'd0);
    chk("rst_cout", {31'd0, cout8}, 32'd0);
    chk("rst_ovf", {31'd0, ovf8}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    run8(8'h05, 8'h03);
    run8(8'hFF, 8'h01);
    run8(8'h7F, 8'h01);

    // Start re-asserted during RUN with different operands must be ignored.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
    q8.push_back(model8(8'h10, 8'h20));
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    repeat (2) @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout("done8_ignore_wait");
    repeat (10) @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h33; start8 = 1'b1;
    q8.push_back(model8(8'h5A, 8'h33));
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy8}, 32'd0);
    chk("arst_done", {31'd0, done8}, 32'd0);
    chk("arst_sum", {24'd0, sum8}, 32'd0);
    chk("arst_cout", {31'd0, cout8}, 32'd0);
    chk("arst_ovf", {31'd0, ovf8}, 32'd0);
    void'(q8.pop_back());
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_sum", {24'd0, sum8}, 32'd0);
    run8(8'h01, 8'h01);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      run8(ra, rb);
    end

    // WIDTH=4 exhaustive, start held high for back-to-back operation.
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] pair;
      pair = 8'(i);
      a4 = pair[7:4];
      b4 = pair[3:0];
      start4 = 1'b1;
      q4.push_back(model4(pair[7:4], pair[3:0]));
      n = 0;
      while (busy4 && n < 20) begin
        @(posedge clk);
        #1 n++;
      end
      n = 0;
      while (!busy4 && n < 20) begin
        @(posedge clk);
        #1 n++;
      end
      if (n >= 20) begin
        timeout("accept4_wait");
        break;
      end
    end
    start4 = 1'b0;
    n = 0;
    while (q4.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);

    chk("q8_drained", q8.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
